c_mux_bus_pipe: RTL and testbench

Parametrised successor to the registered bus multiplexer. It selects one of C_INPUTS channels and carries the result through a C_LATENCY-deep pipeline with valid/ready flow control, so back-pressure stalls the pipeline without losing data. Out-of-range selects are flagged per beat and counted. It sits between channelised datapath stages, such as per-subcarrier or per-antenna buses, and a single downstream consumer.

---
 rtl/c_mux_bus_pipe.sv | 123 ++++++++++++
 tb/tb_c_mux_bus_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_mux_bus_pipe.sv
// c_mux_bus_pipe: picks one of C_INPUTS channels and carries it through a
// C_LATENCY-deep valid/ready pipeline, flagging and counting out-of-range selects.
module c_mux_bus_pipe #(
  parameter int                 C_WIDTH     = 16,
  parameter int                 C_INPUTS    = 8,
  parameter int                 C_SEL_WIDTH = 3,
  parameter int                 C_LATENCY   = 2,
  parameter int                 C_HAS_EN    = 0,
  parameter logic [C_WIDTH-1:0] C_OOR_VAL   = '0,
  parameter int                 C_CNT_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          ACLR_N,
  input  logic                          CE,
  input  logic                          SCLR,
  input  logic [C_INPUTS*C_WIDTH-1:0]   D,
  input  logic [C_SEL_WIDTH-1:0]        S,
  input  logic                          EN,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [C_WIDTH-1:0]            Q,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          OUT_ERR,
  output logic [C_CNT_WIDTH-1:0]        OOR_CNT
);

  localparam int                   LP_NSEL = 2 ** C_SEL_WIDTH;
  localparam logic [C_SEL_WIDTH:0] LP_NIN  = (C_SEL_WIDTH + 1)'(C_INPUTS);

  logic [C_WIDTH-1:0]     w_ch [LP_NSEL];
  logic                   w_oor;
  logic                   w_en;
  logic [C_WIDTH-1:0]     w_val;
  logic                   w_err;
  logic                   w_acc;
  logic [C_CNT_WIDTH-1:0] r_cnt;

  // Select codes beyond C_INPUTS are padded so the index never leaves the array.
  for (genvar g = 0; g < LP_NSEL; g++) begin : g_ch
    if (g < C_INPUTS) begin : g_in
      assign w_ch[g] = D[g*C_WIDTH +: C_WIDTH];
    end else begin : g_pad
      assign w_ch[g] = '0;
    end
  end

  assign w_oor = ({1'b0, S} >= LP_NIN);
  assign w_en  = (C_HAS_EN != 0) ? EN : 1'b1;
  assign w_val = !w_en ? '0 : (w_oor ? C_OOR_VAL : w_ch[S]);
  assign w_err = w_en & w_oor;

  if (C_LATENCY == 0) begin : g_comb
    assign IN_READY  = OUT_READY & CE;
    assign OUT_VALID = IN_VALID & CE;
    assign Q         = w_val;
    assign OUT_ERR   = w_err;
  end else begin : g_pipe
    logic [C_LATENCY-1:0] r_vld;
    logic [C_LATENCY-1:0] r_err;
    logic [C_LATENCY-1:0] w_load;
    logic [C_WIDTH-1:0]   r_dat [C_LATENCY];

    // A stage loads when empty or when the stage ahead loads, so bubbles collapse.
    always_comb begin : p_load
      logic w_ld;
      w_load = '0;
      w_ld = CE & (~r_vld[C_LATENCY-1] | OUT_READY);
      w_load[C_LATENCY-1] = w_ld;
      for (int k = C_LATENCY - 2; k >= 0; k--) begin
        w_ld = CE & (~r_vld[k] | w_ld);
        w_load[k] = w_ld;
      end
    end

    always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
        r_vld <= '0;
        r_err <= '0;
        for (int k = 0; k < C_LATENCY; k++) r_dat[k] <= '0;
      end else if (CE) begin
        if (SCLR) begin
          r_vld <= '0;
        end else begin
          if (w_load[0]) begin
            r_vld[0] <= IN_VALID;
            r_dat[0] <= w_val;
            r_err[0] <= w_err;
          end
          for (int k = 1; k < C_LATENCY; k++) begin
            if (w_load[k]) begin
              r_vld[k] <= r_vld[k-1];
              r_dat[k] <= r_dat[k-1];
              r_err[k] <= r_err[k-1];
            end
          end
        end
      end
    end

    assign IN_READY  = w_load[0];
    assign OUT_VALID = r_vld[C_LATENCY-1];
    assign Q         = r_dat[C_LATENCY-1];
    assign OUT_ERR   = r_err[C_LATENCY-1];
  end

  assign w_acc = IN_VALID & IN_READY & CE;

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_cnt <= '0;
    end else if (CE) begin
      if (SCLR) begin
        r_cnt <= '0;
      end else if (w_acc && w_err && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign OOR_CNT = r_cnt;

endmodule

// File: tb/tb_c_mux_bus_pipe.sv
// Bench for c_mux_bus_pipe: four configurations share one stimulus stream and are
// checked every cycle against a queue-of-beats model, plus literal spot checks.
module tb_c_mux_bus_pipe;

  logic          CLK = 1'b0;
  logic          ACLR_N, CE, SCLR, EN, IN_VALID, OUT_READY;
  logic [127:0]  D;
  logic [2:0]    S;
  logic          in_ready [4];
  logic          ov [4];
  logic          oe [4];
  logic [15:0]   q [4];
  logic [7:0]    cnt [4];

  int total = 0;
  int bad   = 0;

  // model: per instance, beats in flight in order (index 0 = oldest) with position
  int            msz  [4];
  int            mpos [4][8];
  logic [15:0]   mdat [4][8];
  logic          merr [4][8];
  int            mcnt [4];

  always #5 CLK = ~CLK;

  c_mux_bus_pipe #(.C_WIDTH(16), .C_INPUTS(5), .C_SEL_WIDTH(3), .C_LATENCY(2),
    .C_HAS_EN(1), .C_OOR_VAL(16'hDEAD), .C_CNT_WIDTH(8)) u_l2 (
    .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR), .D(D[79:0]), .S(S), .EN(EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[0]), .Q(q[0]), .OUT_VALID(ov[0]),
    .OUT_READY(OUT_READY), .OUT_ERR(oe[0]), .OOR_CNT(cnt[0]));

  c_mux_bus_pipe #(.C_WIDTH(16), .C_INPUTS(5), .C_SEL_WIDTH(3), .C_LATENCY(4),
    .C_HAS_EN(1), .C_OOR_VAL(16'hDEAD), .C_CNT_WIDTH(8)) u_l4 (
    .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR), .D(D[79:0]), .S(S), .EN(EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[1]), .Q(q[1]), .OUT_VALID(ov[1]),
    .OUT_READY(OUT_READY), .OUT_ERR(oe[1]), .OOR_CNT(cnt[1]));

  c_mux_bus_pipe #(.C_WIDTH(16), .C_INPUTS(5), .C_SEL_WIDTH(3), .C_LATENCY(0),
    .C_HAS_EN(1), .C_OOR_VAL(16'hDEAD), .C_CNT_WIDTH(8)) u_l0 (
    .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR), .D(D[79:0]), .S(S), .EN(EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[2]), .Q(q[2]), .OUT_VALID(ov[2]),
    .OUT_READY(OUT_READY), .OUT_ERR(oe[2]), .OOR_CNT(cnt[2]));

  c_mux_bus_pipe #(.C_WIDTH(16), .C_INPUTS(8), .C_SEL_WIDTH(3), .C_LATENCY(1),
    .C_HAS_EN(0), .C_OOR_VAL(16'h0000), .C_CNT_WIDTH(8)) u_l1 (
    .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR), .D(D), .S(S), .EN(EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[3]), .Q(q[3]), .OUT_VALID(ov[3]),
    .OUT_READY(OUT_READY), .OUT_ERR(oe[3]), .OOR_CNT(cnt[3]));

  function automatic int lat(input int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int nin(input int i);
    return (i == 3) ? 8 : 5;
  endfunction

  function automatic bit hen(input int i);
    return (i != 3);
  endfunction

  function automatic logic [15:0] oorv(input int i);
    return (i == 3) ? 16'h0000 : 16'hDEAD;
  endfunction

  function automatic void mux_model(input int i, output logic [15:0] v, output logic e);
    int s;
    s = int'(S);
    if (hen(i) && !EN) begin
      v = 16'h0; e = 1'b0;
    end else if (s >= nin(i)) begin
      v = oorv(i); e = 1'b1;
    end else begin
      v = D[s*16 +: 16]; e = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, i, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      msz[i]  = 0;
      mcnt[i] = 0;
    end
  endtask

  task automatic check_all();
    logic [15:0] v;
    logic        e;
    int          L;
    bit          exp_ov;
    for (int i = 0; i < 4; i++) begin
      mux_model(i, v, e);
      L = lat(i);
      if (L == 0) begin
        chk("ready", i, 32'(in_ready[i]), 32'(OUT_READY & CE));
        chk("valid", i, 32'(ov[i]), 32'(IN_VALID & CE));
        chk("q", i, 32'(q[i]), 32'(v));
        chk("err", i, 32'(oe[i]), 32'(e));
      end else begin
        exp_ov = (msz[i] > 0) && (mpos[i][0] == L - 1);
        chk("ready", i, 32'(in_ready[i]), 32'(CE && (OUT_READY || msz[i] < L)));
        chk("valid", i, 32'(ov[i]), 32'(exp_ov));
        if (exp_ov) begin
          chk("q", i, 32'(q[i]), 32'(mdat[i][0]));
          chk("err", i, 32'(oe[i]), 32'(merr[i][0]));
        end
      end
      chk("cnt", i, 32'(cnt[i]), 32'(mcnt[i]));
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic step_all();
    logic [15:0] v;
    logic        e;
    int          L, lim, np;
    bit          acc;
    for (int i = 0; i < 4; i++) begin
      mux_model(i, v, e);
      L = lat(i);
      acc = 1'b0;
      if (!CE) continue;
      if (SCLR) begin
        msz[i]  = 0;
        mcnt[i] = 0;
        continue;
      end
      if (L == 0) begin
        acc = IN_VALID && OUT_READY;
      end else begin
        acc = IN_VALID && (OUT_READY || msz[i] < L);
        if (msz[i] > 0 && mpos[i][0] == L - 1 && OUT_READY) begin
          for (int j = 1; j < msz[i]; j++) begin
            mpos[i][j-1] = mpos[i][j];
            mdat[i][j-1] = mdat[i][j];
            merr[i][j-1] = merr[i][j];
          end
          msz[i]--;
        end
        for (int j = 0; j < msz[i]; j++) begin
          lim = (j == 0) ? L - 1 : mpos[i][j-1] - 1;
          np  = mpos[i][j] + 1;
          if (np > lim) np = lim;
          mpos[i][j] = np;
        end
        if (acc) begin
          mpos[i][msz[i]] = 0;
          mdat[i][msz[i]] = v;
          merr[i][msz[i]] = e;
          msz[i]++;
        end
      end
      if (acc && e && mcnt[i] < 255) mcnt[i]++;
    end
  endtask

  // Called right after new inputs are applied at a falling edge.
  task automatic tick();
    #1;
    if (!ACLR_N) model_clear();
    check_all();
    if (ACLR_N) step_all();
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    ACLR_N = 1'b0; CE = 1'b1; SCLR = 1'b0; D = '0; S = '0; EN = 1'b1;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    model_clear();
    @(negedge CLK);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      chk("rst_q", i, 32'(q[i]), 32'h0);
      chk("rst_valid", i, 32'(ov[i]), 32'h0);
      chk("rst_err", i, 32'(oe[i]), 32'h0);
      chk("rst_cnt", i, 32'(cnt[i]), 32'h0);
    end
    ACLR_N = 1'b1;

    for (int ch = 0; ch < 8; ch++) D[ch*16 +: 16] = 16'h1000 + 16'(ch);
    IN_VALID = 1'b1;
    for (int s = 0; s < 8; s++) begin
      S = 3'(s);
      tick();
    end
    S = 3'd2;
    ticks(5);
    chk("lit_q_l2", 0, 32'(q[0]), 32'h1002);
    chk("lit_q_l4", 1, 32'(q[1]), 32'h1002);
    chk("lit_q_l0", 2, 32'(q[2]), 32'h1002);
    chk("lit_q_l1", 3, 32'(q[3]), 32'h1002);

    S = 3'd6;
    ticks(5);
    chk("lit_oor_q", 0, 32'(q[0]), 32'hDEAD);
    chk("lit_oor_err", 0, 32'(oe[0]), 32'h1);
    chk("lit_in8_q", 3, 32'(q[3]), 32'h1006);

    EN = 1'b0; S = 3'd7;
    ticks(5);
    chk("lit_en0_q", 0, 32'(q[0]), 32'h0);
    chk("lit_en0_err", 0, 32'(oe[0]), 32'h0);
    chk("lit_noen_q", 3, 32'(q[3]), 32'h1007);

    EN = 1'b1; S = 3'd6;
    ticks(300);
    chk("lit_sat", 0, 32'(cnt[0]), 32'd255);
    chk("lit_sat", 1, 32'(cnt[1]), 32'd255);
    chk("lit_sat", 2, 32'(cnt[2]), 32'd255);
    chk("lit_nosat", 3, 32'(cnt[3]), 32'd0);

    SCLR = 1'b1;
    tick();
    SCLR = 1'b0; IN_VALID = 1'b0;
    chk("lit_sclr_valid", 0, 32'(ov[0]), 32'h0);
    chk("lit_sclr_cnt", 0, 32'(cnt[0]), 32'h0);

    OUT_READY = 1'b0; IN_VALID = 1'b1; S = 3'd1;
    ticks(6);
    chk("lit_bp_ready", 0, 32'(in_ready[0]), 32'h0);
    chk("lit_bp_ready", 1, 32'(in_ready[1]), 32'h0);
    chk("lit_bp_q", 0, 32'(q[0]), 32'h1001);
    chk("lit_bp_valid", 1, 32'(ov[1]), 32'h1);
    OUT_READY = 1'b1;
    for (int s = 2; s < 5; s++) begin
      S = 3'(s);
      tick();
    end

    S = 3'd4; CE = 1'b0;
    ticks(3);
    chk("lit_ce0_ready", 0, 32'(in_ready[0]), 32'h0);
    CE = 1'b1;
    ticks(4);

    S = 3'd5;
    ticks(2);
    ACLR_N = 1'b0;
    tick();
    chk("lit_aclr_valid", 0, 32'(ov[0]), 32'h0);
    chk("lit_aclr_cnt", 0, 32'(cnt[0]), 32'h0);
    ACLR_N = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      D         = {$urandom(), $urandom(), $urandom(), $urandom()};
      S         = 3'($urandom_range(0, 7));
      EN        = ($urandom_range(0, 7) != 0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ((c % 400) < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      CE        = ($urandom_range(0, 9) != 0);
      SCLR      = ($urandom_range(0, 49) == 0);
      ACLR_N    = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
